// File: rtl/acc_seq.sv
// rtl/acc_seq.sv - accumulation sequencer: drives accumulator load/add controls for a counted operand burst (optional watchdog via ACC_SEQ_TIMEOUT_EN)
module acc_seq #(
  parameter int CNT_W   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             op_valid,
  output logic             op_ready,
  output logic             sel,
  output logic             en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_ACC  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] count_inc;
  logic             consume;
  logic             abort;

  // Outputs decode from state; reset masks them so nothing leaks while rst is held.
  assign op_ready  = !rst && ((state_q == S_LOAD) || (state_q == S_ACC));
  assign sel       = !rst && (state_q == S_LOAD);
  assign en        = op_ready && op_valid;
  assign busy      = !rst && (state_q != S_IDLE);
  assign done      = !rst && (state_q == S_DONE);
  assign count     = count_q;
  assign consume   = en;
  assign count_inc = count_q + 1'b1;

`ifdef ACC_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wdog_q, wdog_d;
  logic            err_q;

  // The abort decision is taken on the last allowed stall cycle so the FSM leaves exactly at the limit.
  assign abort = ((state_q == S_LOAD) || (state_q == S_ACC)) && !consume &&
                 (wdog_q == WD_W'(TIMEOUT - 1));
  assign err   = !rst && err_q;

  // Stall counter: counts idle operand cycles, restarts on consume or any state change.
  always_comb begin
    wdog_d = wdog_q;
    if (consume || (state_d != state_q) ||
        !((state_q == S_LOAD) || (state_q == S_ACC))) begin
      wdog_d = '0;
    end else begin
      wdog_d = wdog_q + 1'b1;
    end
  end

  // Watchdog state and the one-cycle error pulse registered off the abort decision.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= abort;
    end
  end
`else
  assign abort = 1'b0;
  assign err   = 1'b0;
`endif

  // Next-state logic for the sequencer; an abort overrides whatever the FSM would do.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    len_d   = len_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          count_d = '0;
          len_d   = len;
          state_d = (len != '0) ? S_LOAD : S_DONE;
        end
      end
      S_LOAD: begin
        if (consume) begin
          count_d = {{(CNT_W-1){1'b0}}, 1'b1};
          state_d = (len_q == {{(CNT_W-1){1'b0}}, 1'b1}) ? S_DONE : S_ACC;
        end
      end
      S_ACC: begin
        if (consume) begin
          count_d = count_inc;
          if (count_inc == len_q) begin
            state_d = S_DONE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (abort) begin
      state_d = S_IDLE;
    end
  end

  // State registers with synchronous reset taking priority over all inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      len_q   <= len_d;
    end
  end

endmodule

// File: tb/tb_acc_seq.sv
// tb/tb_acc_seq.sv - scoreboard bench for acc_seq
module tb_acc_seq;

  localparam int CNT_W = 4;
  localparam int K_EN   = 0;
  localparam int K_DONE = 1;
  localparam int K_ERR  = 2;

  typedef struct {
    int kind;
    int val;
    int gap;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] len;
  logic             op_valid;
  logic             op_ready;
  logic             sel;
  logic             en;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] count;
  logic             err;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   last_cyc = 0;

  acc_seq #(.CNT_W(CNT_W), .TIMEOUT(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .len      (len),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .sel      (sel),
    .en       (en),
    .busy     (busy),
    .done     (done),
    .count    (count),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic push(input int kind, input int val, input int gap);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    e.gap  = gap;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic mon_evt(input int kind, input int val);
    exp_t e;
    int   gap;
    gap      = cyc - last_cyc;
    last_cyc = cyc;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_evt: got kind=%0d val=%0d gap=%0d, expected no event", kind, val, gap);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val != val || e.gap != gap) begin
        fails++;
        $display("FAIL evt: got kind=%0d val=%0d gap=%0d, expected kind=%0d val=%0d gap=%0d",
                 kind, val, gap, e.kind, e.val, e.gap);
      end
    end
  endtask

  // Monitor: samples on the falling edge, pops and compares on each en/done/err
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (en)   mon_evt(K_EN, int'(sel));
      if (done) mon_evt(K_DONE, int'(count));
      if (err)  mon_evt(K_ERR, int'(count));
      if (!rst && start && !busy) last_cyc = cyc;
    end
  end

  task automatic drain(input string name);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) step();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_timeout: got %0d pending events, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    step();
    step();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; op_valid = 1'b0;
    repeat (3) step();
    start = 1'b1; op_valid = 1'b1;
    #1;
    check("rst_hold_busy", int'(busy), 0);
    check("rst_hold_ready", int'(op_ready), 0);
    check("rst_hold_en", int'(en), 0);
    start = 1'b0; op_valid = 1'b0;
    step();
    rst = 1'b0;
    step();
    check("rst_count", int'(count), 0);
    check("rst_outs", int'({op_ready, sel, en, busy, done, err}), 0);

    // len=3, op_valid held high
    push(K_EN, 1, 1); push(K_EN, 0, 1); push(K_EN, 0, 1); push(K_DONE, 3, 1);
    start = 1'b1; len = 4'd3; op_valid = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    op_valid = 1'b0;
    drain("len3");
    check("len3_count_hold", int'(count), 3);

    // len=0 goes straight to DONE and clears count
    push(K_DONE, 0, 1);
    start = 1'b1; len = 4'd0;
    step();
    start = 1'b0;
    drain("len0");
    check("len0_busy", int'(busy), 0);

    // len=4 with toggling op_valid; start pulses and op_valid in DONE ignored
    push(K_EN, 1, 1); push(K_EN, 0, 2); push(K_EN, 0, 2); push(K_EN, 0, 2); push(K_DONE, 4, 1);
    start = 1'b1; len = 4'd4; op_valid = 1'b0;
    step();
    for (int i = 0; i < 8; i++) begin
      start    = (i % 2 == 1);
      op_valid = (i % 2 == 0) || (i == 7);
      step();
    end
    start = 1'b0; op_valid = 1'b0;
    drain("len4_toggle");
    check("len4_idle", int'(busy), 0);

    // len=5 aborted by reset after two consumes
    push(K_EN, 1, 1); push(K_EN, 0, 1);
    start = 1'b1; len = 4'd5; op_valid = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    rst = 1'b1; start = 1'b1;
    #1;
    check("midrst_en", int'(en), 0);
    check("midrst_busy", int'(busy), 0);
    step();
    rst = 1'b0; start = 1'b0; op_valid = 1'b0;
    check("midrst_count", int'(count), 0);
    check("midrst_state", int'({busy, op_ready, done}), 0);
    drain("midrst");

    // stall after one consume
    push(K_EN, 1, 1);
`ifdef ACC_SEQ_TIMEOUT_EN
    push(K_ERR, 1, 17);
`endif
    start = 1'b1; len = 4'd3; op_valid = 1'b1;
    step();
    start = 1'b0;
    step();
    op_valid = 1'b0;
    repeat (20) step();
`ifdef ACC_SEQ_TIMEOUT_EN
    drain("wdog");
    check("wdog_busy", int'(busy), 0);
    check("wdog_count", int'(count), 1);
`else
    check("stall_busy", int'(busy), 1);
    check("stall_ready", int'(op_ready), 1);
    check("stall_count", int'(count), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    drain("stall");
`endif

    // maximum length, no wrap
    push(K_EN, 1, 1);
    for (int i = 0; i < 14; i++) push(K_EN, 0, 1);
    push(K_DONE, 15, 1);
    start = 1'b1; len = 4'd15; op_valid = 1'b1;
    step();
    start = 1'b0;
    repeat (15) step();
    op_valid = 1'b0;
    drain("len15");
    check("len15_count", int'(count), 15);

    // len=1 finishes straight from LOAD
    push(K_EN, 1, 1); push(K_DONE, 1, 1);
    start = 1'b1; len = 4'd1; op_valid = 1'b1;
    step();
    start = 1'b0;
    step();
    op_valid = 1'b0;
    drain("len1");
    check("len1_count", int'(count), 1);

    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/acc_seq.md
ACC_SEQ -- requirements
Module: acc_seq

Interface
REQ-001 Parameter CNT_W, default 4: width of operand-count input and count output.
REQ-002 Parameter TIMEOUT, default 16: idle-operand cycle limit for the watchdog (see Configuration).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to begin one accumulation sequence.
REQ-006 len  input  CNT_W  number of operands to accumulate, sampled on accepted start.
REQ-007 op_valid  input  1  upstream operand present this cycle.
REQ-008 op_ready  output  1  controller can accept an operand this cycle.
REQ-009 sel  output  1  accumulator source select: 1 = load operand (clear-and-load), 0 = add to accumulator.
REQ-010 en  output  1  accumulator register write enable.
REQ-011 busy  output  1  sequence in progress.
REQ-012 done  output  1  one-cycle pulse: accumulator holds the final result.
REQ-013 count  output  CNT_W  operands consumed in the current sequence.
REQ-014 err  output  1  one-cycle pulse on watchdog abort.

Function
REQ-015 FSM states SHALL be IDLE, LOAD, ACC, DONE, encoded in 2 bits.
REQ-016 IDLE: start=1 with len!=0 -> LOAD, len latched into internal register, count cleared; start=1 with len==0 -> DONE; otherwise stay.
REQ-017 start SHALL be ignored in every state other than IDLE.
REQ-018 op_ready SHALL be 1 exactly in LOAD and ACC; 0 elsewhere.
REQ-019 en SHALL equal op_ready AND op_valid, combinationally; an operand is consumed only on such a cycle.
REQ-020 sel SHALL be 1 only in LOAD, so the first consumed operand overwrites the accumulator; sel=0 in all other states.
REQ-021 LOAD: on consume, count becomes 1; latched len==1 -> DONE, else -> ACC; no consume -> stay.
REQ-022 ACC: on consume, count increments by 1; if the incremented value equals latched len -> DONE, else stay.
REQ-023 DONE: done=1 for exactly this one cycle; next state IDLE unconditionally.
REQ-024 busy SHALL be 1 in LOAD, ACC and DONE.
REQ-025 count SHALL hold its final value through DONE and IDLE until the next accepted start clears it.
REQ-026 Latency: start to LOAD is one cycle; last consume to done is one cycle; done to IDLE is one cycle.
REQ-027 len==2^CNT_W-1 (maximum) SHALL complete without count wrap.
REQ-028 op_valid in IDLE or DONE SHALL be ignored (no en, no count change).

Reset
REQ-029 rst=1 at a clock edge SHALL force IDLE, count=0, latched len=0, watchdog=0, regardless of state, including mid-sequence.
REQ-030 During and after reset: op_ready=0, sel=0, en=0, busy=0, done=0, err=0.
REQ-031 rst SHALL take priority over start and op_valid in the same cycle.

Configuration
REQ-032 Macro ACC_SEQ_TIMEOUT_EN SHALL compile in the watchdog.
REQ-033 With ACC_SEQ_TIMEOUT_EN: a counter increments each LOAD/ACC cycle without a consume and clears on consume or state entry. When it reaches TIMEOUT, the FSM SHALL go to IDLE, err SHALL pulse for one cycle, done SHALL stay 0, and count SHALL hold its value.
REQ-034 Without ACC_SEQ_TIMEOUT_EN: no watchdog logic; err SHALL be tied 0; LOAD/ACC wait indefinitely.

Verification
REQ-035 Reset, then start=1, len=3, op_valid held 1 -> sel/en=1 one cycle, then en=1 sel=0 two cycles; done pulses 1 cycle after third consume; count=3.
REQ-036 len=0 start -> DONE next cycle, done=1, en never asserted, count=0.
REQ-037 len=4, op_valid toggling 1/0 every cycle -> exactly 4 en pulses, first with sel=1; done 1 cycle after 4th; start pulses while busy ignored.
REQ-038 len=5, rst=1 after 2 consumes -> next cycle IDLE, busy=0, count=0, no done.
REQ-039 (ACC_SEQ_TIMEOUT_EN, TIMEOUT=16) len=3, one consume then op_valid=0 -> err pulses after 16 stall cycles, FSM IDLE, count=1, done never 1; without macro the FSM stays in ACC.
REQ-040 len=15 (CNT_W=4), op_valid=1 -> 15 consumes, count=15 at done, no wrap.
